vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_timing_gen_if.sv | 37 +++
 rtl/vga_axis_counter.sv | 61 ++++++
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster timing constants, coordinate type and total helper
package vga_pkg;

    // Width of every raster coordinate leaving the timing block.
    localparam int COORD_W   = 12;
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    typedef logic [COORD_W-1:0] coord_t;

    // Default 640x480@60 timing at a 25 MHz pixel rate.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Extra output stages on the sync/blank path when the delay option is built in.
    localparam int DEF_SYNC_DELAY = 2;

    // Length of one axis (line or frame) in pixels or lines.
    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the generator and the drawing stages
interface vga_timing_gen_if;

    logic             pix_en;
    vga_pkg::coord_t  counterX;
    vga_pkg::coord_t  counterY;
    logic             hsync;
    logic             vsync;
    logic             blank_n;
    logic             line_end;
    logic             frame_end;

    // The timing generator consumes the pixel qualifier and drives the raster.
    modport master (
        input  pix_en,
        output counterX,
        output counterY,
        output hsync,
        output vsync,
        output blank_n,
        output line_end,
        output frame_end
    );

    // Drawing stages and game logic supply the qualifier and follow the raster.
    modport slave (
        output pix_en,
        input  counterX,
        input  counterY,
        input  hsync,
        input  vsync,
        input  blank_n,
        input  line_end,
        input  frame_end
    );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping axis counter with active/sync window decode
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   step,
    output coord_t count_o,
    output logic   sync_n_o,
    output logic   active_nxt_o,
    output logic   last_nxt_o
);

    localparam coord_t LAST_C       = coord_t'(TOTAL - 1);
    localparam coord_t ACTIVE_C     = coord_t'(ACTIVE);
    localparam coord_t SYNC_START_C = coord_t'(SYNC_START);
    localparam coord_t SYNC_END_C   = coord_t'(SYNC_END);

    coord_t count_d, count_q;
    logic   sync_n_d, sync_n_q;
    logic   active_d;
    logic   last_d;

    // Next position, and the window flags decoded from it so that the
    // registered flags describe the same position as the registered count.
    always_comb begin
        count_d = count_q;
        if (step) begin
            if (count_q == LAST_C) begin
                count_d = '0;
            end else begin
                count_d = count_q + coord_t'(1);
            end
        end
        sync_n_d = !((count_d >= SYNC_START_C) && (count_d < SYNC_END_C));
        active_d = (count_d < ACTIVE_C);
        last_d   = (count_d == LAST_C);
    end

    // Position and sync flop; holding step low leaves both unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= '0;
            sync_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count_o      = count_q;
    assign sync_n_o     = sync_n_q;
    assign active_nxt_o = active_d;
    assign last_nxt_o   = last_d;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator; VGA_TIMING_SYNC_DLY_EN adds SYNC_DELAY stages on hsync/vsync/blank_n
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic             clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // The coordinates are 12 bits wide, so neither axis may exceed 4095.
    if (H_TOTAL > COORD_MAX) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL %0d does not fit in %0d bits", H_TOTAL, COORD_W);
    end
    if (V_TOTAL > COORD_MAX) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL %0d does not fit in %0d bits", V_TOTAL, COORD_W);
    end
    if (SYNC_DELAY < 1) begin : g_sync_delay_chk
        $error("vga_timing_gen: SYNC_DELAY must be at least 1");
    end

    coord_t h_count, v_count;
    logic   h_sync_n, v_sync_n;
    logic   h_active_nxt, v_active_nxt;
    logic   h_last_nxt, v_last_nxt;
    logic   v_step;

    logic   line_end_d, line_end_q;
    logic   frame_end_d, frame_end_q;
    logic   blank_n_d, blank_n_q;

    // The line counter only moves on the pixel that closes a line.
    assign v_step = vif.pix_en & line_end_q;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .step         (vif.pix_en),
        .count_o      (h_count),
        .sync_n_o     (h_sync_n),
        .active_nxt_o (h_active_nxt),
        .last_nxt_o   (h_last_nxt)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .step         (v_step),
        .count_o      (v_count),
        .sync_n_o     (v_sync_n),
        .active_nxt_o (v_active_nxt),
        .last_nxt_o   (v_last_nxt)
    );

    // Strobes and blanking from the next position of both axes, held when pix_en is low.
    always_comb begin
        line_end_d  = line_end_q;
        frame_end_d = frame_end_q;
        blank_n_d   = blank_n_q;
        if (vif.pix_en) begin
            line_end_d  = h_last_nxt;
            frame_end_d = h_last_nxt & v_last_nxt;
            blank_n_d   = h_active_nxt & v_active_nxt;
        end
    end

    // Strobe and blanking registers; reset lands on pixel (0,0), which is visible.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            blank_n_q   <= 1'b1;
        end else begin
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
            blank_n_q   <= blank_n_d;
        end
    end

    assign vif.counterX  = h_count;
    assign vif.counterY  = v_count;
    assign vif.line_end  = line_end_q;
    assign vif.frame_end = frame_end_q;

`ifdef VGA_TIMING_SYNC_DLY_EN
    logic [SYNC_DELAY-1:0] hs_dly_d, hs_dly_q;
    logic [SYNC_DELAY-1:0] vs_dly_d, vs_dly_q;
    logic [SYNC_DELAY-1:0] bl_dly_d, bl_dly_q;

    // Shift the sync/blank levels one pixel deeper on each qualified pixel;
    // the oldest stage matches a colour pipeline SYNC_DELAY pixels long.
    always_comb begin
        hs_dly_d = hs_dly_q;
        vs_dly_d = vs_dly_q;
        bl_dly_d = bl_dly_q;
        if (vif.pix_en) begin
            hs_dly_d = (hs_dly_q << 1) | SYNC_DELAY'(h_sync_n);
            vs_dly_d = (vs_dly_q << 1) | SYNC_DELAY'(v_sync_n);
            bl_dly_d = (bl_dly_q << 1) | SYNC_DELAY'(blank_n_q);
        end
    end

    // Delay stages come out of reset with syncs inactive and the screen blanked.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_dly_q <= '1;
            vs_dly_q <= '1;
            bl_dly_q <= '0;
        end else begin
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
            bl_dly_q <= bl_dly_d;
        end
    end

    assign vif.hsync   = hs_dly_q[SYNC_DELAY-1];
    assign vif.vsync   = vs_dly_q[SYNC_DELAY-1];
    assign vif.blank_n = bl_dly_q[SYNC_DELAY-1];
`else
    assign vif.hsync   = h_sync_n;
    assign vif.vsync   = v_sync_n;
    assign vif.blank_n = blank_n_q;
`endif

endmodule
